// File: rtl/pwm_pkg.sv
// Shared types for the PWM commutator: leg states, phase roles and the forward
// hall commutation table (phase index 0=A, 1=B, 2=C).
package pwm_pkg;

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_H_ON = 2'd1,
    LEG_DEAD = 2'd2,
    LEG_L_ON = 2'd3
  } leg_state_t;

  typedef enum logic [1:0] {
    ROLE_OFF = 2'd0,
    ROLE_PWM = 2'd1,
    ROLE_LOW = 2'd2
  } phase_role_t;

  typedef logic [1:0] phase_idx_t;

  typedef struct packed {
    logic       valid;
    phase_idx_t pwm_ph;
    phase_idx_t low_ph;
  } comm_entry_t;

  localparam phase_idx_t PH_A = 2'd0;
  localparam phase_idx_t PH_B = 2'd1;
  localparam phase_idx_t PH_C = 2'd2;

  // Indexed by hall code {A,B,C}; 000 and 111 are illegal sensor states.
  localparam comm_entry_t FWD_TABLE [8] = '{
    '{1'b0, PH_A, PH_A},
    '{1'b1, PH_C, PH_B},
    '{1'b1, PH_B, PH_A},
    '{1'b1, PH_C, PH_A},
    '{1'b1, PH_A, PH_C},
    '{1'b1, PH_A, PH_B},
    '{1'b1, PH_B, PH_C},
    '{1'b0, PH_A, PH_A}
  };

  // Reverse rotation reuses the forward table with PWM and low roles exchanged.
  function automatic phase_role_t phase_role(input comm_entry_t e, input phase_idx_t ph,
                                             input logic fwd);
    phase_role_t r;
    r = ROLE_OFF;
    if (e.valid && ph == e.pwm_ph) begin
      r = fwd ? ROLE_PWM : ROLE_LOW;
    end else if (e.valid && ph == e.low_ph) begin
      r = fwd ? ROLE_LOW : ROLE_PWM;
    end
    return r;
  endfunction

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: OFF/H_ON/DEAD/L_ON with registered gates; every switch
// between sides is blanked for max(dead_time,1) cycles.
module deadtime_leg
  import pwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  leg_state_t          i_req,
  input  logic                i_kill,
  input  logic [DT_WIDTH-1:0] i_dead_time,
  output logic                o_h,
  output logic                o_l
);

  leg_state_t          r_state;
  leg_state_t          w_state_nxt;
  logic [DT_WIDTH-1:0] r_dead_cnt;
  logic [DT_WIDTH-1:0] w_dead_cnt_nxt;
  logic [DT_WIDTH-1:0] w_dead_load;
  logic                r_h;
  logic                r_l;

  // Counter holds remaining DEAD cycles minus one, so a zero dead_time still blanks once.
  assign w_dead_load = (i_dead_time == '0) ? '0 : i_dead_time - DT_WIDTH'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_dead_cnt_nxt = r_dead_cnt;
    if (i_kill || i_req == LEG_OFF) begin
      w_state_nxt    = LEG_OFF;
      w_dead_cnt_nxt = '0;
    end else begin
      case (r_state)
        LEG_OFF: begin
          w_state_nxt    = LEG_DEAD;
          w_dead_cnt_nxt = w_dead_load;
        end
        LEG_H_ON, LEG_L_ON: begin
          if (i_req != r_state) begin
            w_state_nxt    = LEG_DEAD;
            w_dead_cnt_nxt = w_dead_load;
          end
        end
        LEG_DEAD: begin
          if (r_dead_cnt == '0) begin
            w_state_nxt = i_req;
          end else begin
            w_dead_cnt_nxt = r_dead_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt    = LEG_OFF;
          w_dead_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LEG_OFF;
      r_dead_cnt <= '0;
      r_h        <= 1'b0;
      r_l        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dead_cnt <= w_dead_cnt_nxt;
      r_h        <= (w_state_nxt == LEG_H_ON);
      r_l        <= (w_state_nxt == LEG_L_ON);
    end
  end

  assign o_h = r_h;
  assign o_l = r_l;

endmodule

// File: rtl/pwm_deadtime_commutator.sv
// Hall-commutated three-phase PWM driver with per-leg dead time and a sticky
// invalid-hall fault. Define HALL_FILTER_EN to require FILT_LEN stable hall samples.
module pwm_deadtime_commutator
  import pwm_pkg::*;
#(
  parameter int unsigned DWIDTH   = 10,
  parameter int unsigned DT_WIDTH = 6,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                forward,
  input  logic [DWIDTH-1:0]   duty,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic [2:0]          hall,
  output logic [2:0]          pwm_h,
  output logic [2:0]          pwm_l,
  output logic                fault,
  output logic                period_start
);

  localparam logic [DWIDTH-1:0] CNT_MAX = {{(DWIDTH-1){1'b1}}, 1'b0};

  logic [2:0]        r_hall_s1;
  logic [2:0]        r_hall_s2;
  logic [2:0]        w_hall_acc;
  comm_entry_t       w_entry;
  logic              w_kill;
  logic [DWIDTH-1:0] r_cnt;
  logic [DWIDTH-1:0] w_cnt_nxt;
  logic [DWIDTH-1:0] r_duty_q;
  logic              w_pwm_raw;
  logic              r_fault;
  logic              r_period_start;
  leg_state_t        r_req     [3];
  leg_state_t        w_req_nxt [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hall_s1 <= '0;
      r_hall_s2 <= '0;
    end else begin
      r_hall_s1 <= hall;
      r_hall_s2 <= r_hall_s1;
    end
  end

`ifdef HALL_FILTER_EN
  localparam int unsigned FILT_CW = $clog2(FILT_LEN + 1);

  logic [2:0]         r_filt_cand;
  logic [2:0]         r_hall_acc;
  logic [FILT_CW-1:0] r_filt_cnt;
  logic [FILT_CW-1:0] w_filt_cnt_nxt;

  always_comb begin
    if (r_hall_s2 != r_filt_cand) begin
      w_filt_cnt_nxt = FILT_CW'(1);
    end else if (r_filt_cnt >= FILT_CW'(FILT_LEN)) begin
      w_filt_cnt_nxt = r_filt_cnt;
    end else begin
      w_filt_cnt_nxt = r_filt_cnt + FILT_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_cand <= '0;
      r_filt_cnt  <= '0;
      r_hall_acc  <= '0;
    end else begin
      r_filt_cand <= r_hall_s2;
      r_filt_cnt  <= w_filt_cnt_nxt;
      if (w_filt_cnt_nxt >= FILT_CW'(FILT_LEN)) begin
        r_hall_acc <= r_hall_s2;
      end
    end
  end

  assign w_hall_acc = r_hall_acc;
`else
  assign w_hall_acc = r_hall_s2;
`endif

  assign w_entry = FWD_TABLE[w_hall_acc];
  // An illegal code drops the legs on the same edge that raises fault.
  assign w_kill  = !enable || r_fault || !w_entry.valid;

  assign w_cnt_nxt = !enable ? '0 : ((r_cnt == CNT_MAX) ? '0 : r_cnt + DWIDTH'(1));
  assign w_pwm_raw = (r_cnt < r_duty_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_duty_q       <= '0;
      r_period_start <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_period_start <= enable && (w_cnt_nxt == '0);
      // Loaded on the edge entering count 0 so the whole new period sees it.
      if (w_cnt_nxt == '0) begin
        r_duty_q <= duty;
      end
      if (!enable) begin
        r_fault <= 1'b0;
      end else if (!w_entry.valid) begin
        r_fault <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_req_nxt[i] = LEG_OFF;
      if (!w_kill) begin
        case (phase_role(w_entry, phase_idx_t'(i), forward))
          ROLE_PWM: w_req_nxt[i] = w_pwm_raw ? LEG_H_ON : LEG_L_ON;
          ROLE_LOW: w_req_nxt[i] = LEG_L_ON;
          default:  w_req_nxt[i] = LEG_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '{default: LEG_OFF};
    end else begin
      r_req <= w_req_nxt;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_leg
    deadtime_leg #(
      .DT_WIDTH(DT_WIDTH)
    ) u_leg (
      .clk        (clk),
      .rst        (rst),
      .i_req      (r_req[g]),
      .i_kill     (w_kill),
      .i_dead_time(dead_time),
      .o_h        (pwm_h[2-g]),
      .o_l        (pwm_l[2-g])
    );
  end

  assign fault        = r_fault;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_deadtime_commutator.sv
// Self-checking bench for pwm_deadtime_commutator: directed scenarios plus a long
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_pwm_deadtime_commutator;

  localparam int DW     = 4;
  localparam int DTW    = 6;
  localparam int FL     = 4;
  localparam int PERIOD = (1 << DW) - 1;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic           enable    = 1'b0;
  logic           forward   = 1'b1;
  logic [DW-1:0]  duty      = '0;
  logic [DTW-1:0] dead_time = '0;
  logic [2:0]     hall      = 3'b101;
  logic [2:0]     pwm_h;
  logic [2:0]     pwm_l;
  logic           fault;
  logic           period_start;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_deadtime_commutator #(
    .DWIDTH  (DW),
    .DT_WIDTH(DTW),
    .FILT_LEN(FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .forward     (forward),
    .duty        (duty),
    .dead_time   (dead_time),
    .hall        (hall),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .fault       (fault),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Model: bit b of the gate buses (2=A,1=B,0=C); side 0=none, 1=high, 2=low.
  int hq [8];
  int m_acc   = 0;
  int m_pos   = 0;
  int m_duty  = 0;
  int m_fault = 0;
  int m_ps    = 0;
  int m_req   [3];
  int m_on    [3];
  int m_blank [3];
  int w_h     [3];
  int w_l     [3];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Role of phase bit b for a hall code: 0 off, 1 PWM, 2 constant low.
  function automatic int role_of(input int code, input int b, input int fwd);
    int p, l, t;
    case (code)
      5: begin p = 2; l = 1; end
      4: begin p = 2; l = 0; end
      6: begin p = 1; l = 0; end
      2: begin p = 1; l = 2; end
      3: begin p = 0; l = 2; end
      1: begin p = 0; l = 1; end
      default: return 0;
    endcase
    if (fwd == 0) begin t = p; p = l; l = t; end
    if (b == p) return 1;
    if (b == l) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    int  new_req [3];
    int  raw, dtn, r;
    bit  stop, same;
    stop = !enable || m_fault != 0 || m_acc == 0 || m_acc == 7;
    raw  = (m_pos < m_duty) ? 1 : 0;
    dtn  = (dead_time == 0) ? 1 : int'(dead_time);
    for (int b = 0; b < 3; b++) begin
      r = role_of(m_acc, b, int'(forward));
      if (stop || r == 0) new_req[b] = 0;
      else if (r == 2)    new_req[b] = 2;
      else                new_req[b] = (raw != 0) ? 1 : 2;
      if (stop || m_req[b] == 0) begin
        m_on[b] = 0; m_blank[b] = 0;
      end else if (m_blank[b] > 0) begin
        m_blank[b]--;
        if (m_blank[b] == 0) m_on[b] = m_req[b];
      end else if (m_on[b] != m_req[b]) begin
        m_on[b] = 0; m_blank[b] = dtn;
      end
    end
    for (int b = 0; b < 3; b++) m_req[b] = new_req[b];
    m_fault = (enable && (m_fault != 0 || m_acc == 0 || m_acc == 7)) ? 1 : 0;
    m_pos   = enable ? (m_pos + 1) % PERIOD : 0;
    m_ps    = (enable && m_pos == 0) ? 1 : 0;
    if (m_pos == 0) m_duty = int'(duty);
    for (int j = 7; j > 0; j--) hq[j] = hq[j-1];
    hq[0] = int'(hall);
`ifdef HALL_FILTER_EN
    same = 1'b1;
    for (int j = 3; j < FL + 2; j++) if (hq[j] != hq[2]) same = 1'b0;
    if (same) m_acc = hq[2];
`else
    same   = 1'b0;
    m_acc  = hq[1] + int'(same);
`endif
  endtask

  function automatic int exp_gates();
    int g;
    g = 0;
    for (int b = 0; b < 3; b++) begin
      if (m_on[b] == 1) g = g | (1 << (b + 3));
      if (m_on[b] == 2) g = g | (1 << b);
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("gates", int'({pwm_h, pwm_l}), exp_gates());
    check("fault", int'(fault), m_fault);
    check("period_start", int'(period_start), m_ps);
    check("no_overlap", int'(pwm_h & pwm_l), 0);
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!period_start && k < 3 * PERIOD);
    check("period_start_seen", int'(period_start), 1);
  endtask

  // Counts gate-on cycles over one period starting at the current period_start sample.
  task automatic window(input int chg_at, input int new_duty);
    for (int b = 0; b < 3; b++) begin w_h[b] = 0; w_l[b] = 0; end
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) begin
        if (i == chg_at) duty = DW'(new_duty);
        tick();
      end
      for (int b = 0; b < 3; b++) begin
        w_h[b] += int'(pwm_h[b]);
        w_l[b] += int'(pwm_l[b]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] valid_codes [6];
    int prev, gap, side, cnt, r;
    valid_codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    for (int j = 0; j < 8; j++) hq[j] = 0;
    for (int b = 0; b < 3; b++) begin m_req[b] = 0; m_on[b] = 0; m_blank[b] = 0; end

    // Reset state
    duty = DW'(5); dead_time = DTW'(1); hall = 3'b101; forward = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gates", int'({pwm_h, pwm_l}), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_period_start", int'(period_start), 0);
    rst = 1'b0;
    repeat (6) tick();

    // duty 5 forward 101: A PWM, B low, C off
    enable = 1'b1;
    repeat (3 * PERIOD) tick();
    wait_ps();
    window(-1, 0);
    check("duty5_hA", w_h[2], 5 - 1);
    check("duty5_lB", w_l[1], PERIOD);
    check("duty5_C_off", w_h[0] + w_l[0], 0);

    // dead_time 3: every A side change blanked exactly 3 cycles
    dead_time = DTW'(3);
    repeat (2 * PERIOD) tick();
    prev = 0; gap = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      tick();
      side = pwm_h[2] ? 1 : (pwm_l[2] ? 2 : 0);
      if (side == 0) gap++;
      else begin
        if (prev != 0 && side != prev) check("dead_gap", gap, 3);
        gap = 0; prev = side;
      end
    end
    wait_ps();
    window(-1, 0);
    check("dt3_hA", w_h[2], 5 - 3);

    // mid-period duty change takes effect at the next period
    dead_time = DTW'(1);
    repeat (2 * PERIOD) tick();
    wait_ps();
    window(7, 12);
    check("duty_old_period", w_h[2], 5 - 1);
    wait_ps();
    window(-1, 0);
    check("duty_new_period", w_h[2], 12 - 1);

    // invalid hall -> sticky fault, recovery via enable
    duty = DW'(5);
    hall = 3'b111;
    tick();
    check("fault_sync_lat1", int'(fault), 0);
    tick();
    check("fault_sync_lat2", int'(fault), 0);
    tick();
    check("fault_set", int'(fault), 1);
    check("fault_gates_off", int'({pwm_h, pwm_l}), 0);
    hall = 3'b100;
    repeat (10) tick();
    check("fault_sticky", int'(fault), 1);
    enable = 1'b0;
    tick();
    check("fault_clear", int'(fault), 0);
    enable = 1'b1;
    repeat (3 * PERIOD) tick();
    wait_ps();
    window(-1, 0);
    check("resume_lC", w_l[0], PERIOD);
    check("resume_hA", w_h[2], 5 - 1);
    check("resume_B_off", w_h[1] + w_l[1], 0);

`ifdef HALL_FILTER_EN
    hall = 3'b101;
    repeat (3 * PERIOD) tick();
    hall = 3'b100;
    repeat (3) tick();
    hall = 3'b101;
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(pwm_l[1]); end
    check("glitch3_ignored_lB", cnt, 20);
    hall = 3'b100;
    repeat (4) tick();
    hall = 3'b101;
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(pwm_l[0]); end
    check("stable4_accepted", (cnt > 0) ? 1 : 0, 1);
`endif

    // randomized run
    for (int i = 0; i < 10000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 100) hall = valid_codes[$urandom_range(0, 5)];
      else if (r < 105) hall = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
      if ($urandom_range(0, 19) == 0) duty = DW'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) dead_time = DTW'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) forward = ~forward;
      if (!enable) enable = 1'b1;
      else if ($urandom_range(0, 149) == 0) enable = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
